sevenseg_scanner: RTL and testbench
===================================

SEVENSEG_SCANNER -- requirements
Module: sevenseg_scanner

Interface
REQ-001 Parameter: NUM_DIGITS, default 8, number of multiplexed digits (2..8).
REQ-002 Parameter: BLANK_CYCLES, default 16, all-off clock cycles inserted between digits (>=1).
REQ-003 clk  input  1  system clock, 100 MHz.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 en  input  1  scan enable; 0 forces all digits off.
REQ-006 tick  input  1  one-cycle refresh strobe from the anode tick generator.
REQ-007 digits  input  4*NUM_DIGITS  hex nibble per digit; digit i at [4i+3:4i].
REQ-008 dp  input  NUM_DIGITS  decimal point per digit, active-high.
REQ-009 blank_mask  input  NUM_DIGITS  1 = digit i suppressed.
REQ-010 load  input  1  one-cycle strobe requesting capture of digits/dp/blank_mask.
REQ-011 an  output  NUM_DIGITS  anode enables, active-low, at most one low.
REQ-012 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-013 dp_n  output  1  decimal-point cathode, active-low.
REQ-014 frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-015 The block SHALL hold shadow registers for digits, dp and blank_mask; the outputs SHALL be derived only from the shadow copies.
REQ-016 The FSM SHALL have states IDLE, DRIVE, BLANK; a digit index idx, range 0..NUM_DIGITS-1; and a blank counter sized for BLANK_CYCLES.
REQ-017 IDLE: an all 1, seg all 1, dp_n 1; on tick with en=1, go to DRIVE with idx=0.
REQ-018 DRIVE: an[idx]=0 and the decoded shadow nibble on seg/dp_n; on tick, go to BLANK and advance idx (NUM_DIGITS-1 wraps to 0).
REQ-019 BLANK: all outputs off; count BLANK_CYCLES cycles, then go to DRIVE; ticks during BLANK SHALL be ignored.
REQ-020 en=0 in any state SHALL force IDLE and idx=0 on the next cycle; outputs go off on that same next cycle.
REQ-021 an, seg and dp_n SHALL be registered: they reflect the state and idx of the previous cycle (1-cycle latency).
REQ-022 A digit with shadow blank_mask[idx]=1 SHALL keep an all 1 in DRIVE; timing is unchanged.
REQ-023 Hex decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-024 load SHALL set a pending flag; the pending capture SHALL occur on the idx wrap to 0, or immediately when in IDLE; the flag then clears.
REQ-025 load coincident with the wrap SHALL capture in that same cycle; repeated loads before the wrap SHALL capture the latest input values.
REQ-026 frame_done SHALL pulse exactly one cycle, on the cycle idx wraps from NUM_DIGITS-1 to 0.
REQ-027 tick coincident with en falling SHALL be ignored (en=0 has priority).

Reset
REQ-028 rst_n=0 SHALL asynchronously force: IDLE, idx=0, blank counter 0, pending 0, shadows 0, an all 1, seg 7'b1111111, dp_n 1, frame_done 0.
REQ-029 Reset mid-DRIVE SHALL turn all anodes off immediately, without waiting for a clock; after release, scanning restarts at digit 0 on the next tick.

Structure
REQ-030 Package sevenseg_pkg SHALL hold the state enum (IDLE/DRIVE/BLANK), the SEG_OFF constant and the 16-entry hex pattern constants.
REQ-031 Sub-module hex_to_seg (combinational, 4-bit in, 7-bit active-low out) SHALL implement REQ-023; a single instance is used.

Verification
REQ-032 Reset: rst_n low mid-DRIVE -> an=8'hFF, seg=7'h7F, dp_n=1 before the next clk edge.
REQ-033 Scan: digits=32'h76543210, load, en=1, tick every 100 cycles -> an steps FE,FD,...,7F, seg shows 0..7 patterns, each digit separated by 16 all-off cycles.
REQ-034 Wrap: after digit 7, frame_done pulses 1 cycle, then an=FE; 3 frames -> exactly 3 pulses.
REQ-035 Deferred load: load 32'hFFFFFFFF while idx=3 -> digits 4..7 keep their old values; from digit 0, seg=0001110.
REQ-036 Blank/dp: blank_mask=8'h02, dp=8'h01 -> digit 1 slot keeps an=FF; digit 0 shows dp_n=0.
REQ-037 en drop: en=0 during DRIVE of digit 5 -> outputs off next cycle; en=1 plus tick -> restart at an=FE.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } state_t;

  // All cathodes released (active-low segments).
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} patterns, entry n displays hex digit n.
  localparam logic [15:0][6:0] HEX_PAT = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/sevenseg_scanner_hex_to_seg.sv
// Hex nibble to active-low seven-segment pattern.
// Latency: combinational.
// Backpressure: none.
module hex_to_seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_PAT[nib];

endmodule

// File: rtl/sevenseg_scanner.sv
// Multiplexed seven-segment scanner: one digit driven per tick, all-off gap between digits.
// Latency: an/seg/dp_n registered, one cycle behind state/idx; frame_done one cycle after the wrap edge.
// Backpressure: none; load is held pending until the frame wraps (or taken at once when idle).
module sevenseg_scanner
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    tick,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(BLANK_CYCLES + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic [CW-1:0]   bcnt, bcnt_nxt;
  logic            wrap;
  logic            cap_win;
  logic            pending;

  logic [4*NUM_DIGITS-1:0] stg_digits, sh_digits;
  logic [NUM_DIGITS-1:0]   stg_dp, sh_dp;
  logic [NUM_DIGITS-1:0]   stg_blank, sh_blank;

  logic [3:0] cur_nib;
  logic [6:0] dec_seg;

  // State, digit index and blank counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  // Next-state logic; en low overrides everything, including a coincident tick.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    bcnt_nxt  = bcnt;
    wrap      = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      bcnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            state_nxt = DRIVE;
            idx_nxt   = '0;
            bcnt_nxt  = '0;
          end
        end
        DRIVE: begin
          if (tick) begin
            state_nxt = BLANK;
            bcnt_nxt  = '0;
            if (idx == IDX_LAST) begin
              idx_nxt = '0;
              wrap    = 1'b1;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end
        end
        BLANK: begin
          // Ticks are ignored here; the gap length is fixed by the counter.
          if (bcnt == CNT_LAST) begin
            state_nxt = DRIVE;
            bcnt_nxt  = '0;
          end else begin
            bcnt_nxt = bcnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          bcnt_nxt  = '0;
        end
      endcase
    end
  end

  // Shadow updates are only allowed where they cannot tear a frame.
  assign cap_win = wrap || (state == IDLE);

  // Pending flag and staging copy of the most recent load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      stg_digits <= '0;
      stg_dp     <= '0;
      stg_blank  <= '0;
    end else begin
      if (cap_win)   pending <= 1'b0;
      else if (load) pending <= 1'b1;
      if (load) begin
        stg_digits <= digits;
        stg_dp     <= dp;
        stg_blank  <= blank_mask;
      end
    end
  end

  // Shadow registers: a load in the capture cycle wins over an older staged one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
    end else if (cap_win && load) begin
      sh_digits <= digits;
      sh_dp     <= dp;
      sh_blank  <= blank_mask;
    end else if (cap_win && pending) begin
      sh_digits <= stg_digits;
      sh_dp     <= stg_dp;
      sh_blank  <= stg_blank;
    end
  end

  assign cur_nib = sh_digits[{idx, 2'b00} +: 4];

  hex_to_seg u_dec (
    .nib (cur_nib),
    .seg (dec_seg)
  );

  // Registered display outputs; en low turns them off on the very next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an   <= AN_OFF;
      seg  <= SEG_OFF;
      dp_n <= 1'b1;
    end else if (!en || state != DRIVE || sh_blank[idx]) begin
      an   <= AN_OFF;
      seg  <= SEG_OFF;
      dp_n <= 1'b1;
    end else begin
      an   <= ~(NUM_DIGITS'(1) << idx);
      seg  <= dec_seg;
      dp_n <= ~sh_dp[idx];
    end
  end

  // One-cycle end-of-frame pulse following the wrap edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done <= 1'b0;
    else        frame_done <= wrap;
  end

endmodule

// File: tb/tb_sevenseg_scanner.sv
module tb_sevenseg_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        tick = 1'b0;
  logic [31:0] digits = '0;
  logic [7:0]  dp = '0;
  logic [7:0]  blank_mask = '0;
  logic        load = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_done;

  int checks = 0;
  int fails = 0;
  int fd_count = 0;

  logic [6:0] exp_pat [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  sevenseg_scanner #(.NUM_DIGITS(8), .BLANK_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .tick       (tick),
    .digits     (digits),
    .dp         (dp),
    .blank_mask (blank_mask),
    .load       (load),
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (frame_done === 1'b1) fd_count++;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // Steps until an anode is driven again; n = number of all-off cycles seen (64 = timeout).
  task automatic count_off(output int n);
    step();
    n = 0;
    while (an === 8'hFF && n < 64) begin
      n++;
      step();
    end
  endtask

  // Dwell briefly on the current digit, end it with a tick, run through the gap.
  task automatic next_digit(output int n);
    step();
    step();
    pulse_tick();
    count_off(n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (an !== 8'hFF) begin fails++; $display("FAIL reset_an: got %h want ff", an); end
    checks++; if (seg !== 7'h7F) begin fails++; $display("FAIL reset_seg: got %h want 7f", seg); end
    checks++; if (dp_n !== 1'b1) begin fails++; $display("FAIL reset_dp_n: got %b want 1", dp_n); end
    checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_scan();
    int n;
    logic [7:0] exp_an;
    en = 1'b0;
    digits = 32'h76543210;
    dp = 8'h00;
    blank_mask = 8'h00;
    load = 1'b1;
    step();
    load = 1'b0;
    en = 1'b1;
    step();
    pulse_tick();
    step();
    for (int d = 0; d < 8; d++) begin
      exp_an = ~(8'h01 << d);
      checks++; if (an !== exp_an) begin fails++; $display("FAIL scan_an[%0d]: got %h want %h", d, an, exp_an); end
      checks++; if (seg !== exp_pat[d]) begin fails++; $display("FAIL scan_seg[%0d]: got %b want %b", d, seg, exp_pat[d]); end
      checks++; if (dp_n !== 1'b1) begin fails++; $display("FAIL scan_dp_n[%0d]: got %b want 1", d, dp_n); end
      if (d < 7) begin
        next_digit(n);
        checks++; if (n != 16) begin fails++; $display("FAIL scan_gap[%0d]: got %0d off cycles want 16", d, n); end
      end
    end
    step();
    step();
    pulse_tick();
    checks++; if (frame_done !== 1'b1) begin fails++; $display("FAIL scan_frame_done: got %b want 1", frame_done); end
    count_off(n);
    checks++; if (n != 16) begin fails++; $display("FAIL scan_wrap_gap: got %0d want 16", n); end
    checks++; if (an !== 8'hFE) begin fails++; $display("FAIL scan_wrap_an: got %h want fe", an); end
  endtask

  task automatic test_wrap();
    int n;
    fd_count = 0;
    for (int i = 0; i < 24; i++) next_digit(n);
    checks++; if (fd_count != 3) begin fails++; $display("FAIL wrap_pulses: got %0d pulse cycles want 3", fd_count); end
    checks++; if (an !== 8'hFE) begin fails++; $display("FAIL wrap_an: got %h want fe", an); end
    checks++; if (frame_done !== 1'b0) begin fails++; $display("FAIL wrap_fd_low: got %b want 0", frame_done); end
  endtask

  task automatic test_deferred_load();
    int n;
    logic [7:0] exp_an;
    for (int i = 0; i < 3; i++) next_digit(n);
    checks++; if (an !== 8'hF7) begin fails++; $display("FAIL defer_at3: got %h want f7", an); end
    digits = 32'hAAAAAAAA;
    load = 1'b1;
    step();
    digits = 32'hFFFFFFFF;
    step();
    load = 1'b0;
    checks++; if (seg !== exp_pat[3]) begin fails++; $display("FAIL defer_seg3: got %b want %b", seg, exp_pat[3]); end
    for (int d = 4; d < 8; d++) begin
      next_digit(n);
      exp_an = ~(8'h01 << d);
      checks++; if (an !== exp_an) begin fails++; $display("FAIL defer_an[%0d]: got %h want %h", d, an, exp_an); end
      checks++; if (seg !== exp_pat[d]) begin fails++; $display("FAIL defer_seg[%0d]: got %b want %b", d, seg, exp_pat[d]); end
    end
    next_digit(n);
    checks++; if (an !== 8'hFE) begin fails++; $display("FAIL defer_wrap_an: got %h want fe", an); end
    checks++; if (seg !== 7'b0001110) begin fails++; $display("FAIL defer_new_seg: got %b want 0001110", seg); end
  endtask

  task automatic test_blank_dp();
    int n;
    int bad;
    for (int i = 0; i < 7; i++) next_digit(n);
    checks++; if (an !== 8'h7F) begin fails++; $display("FAIL blank_at7: got %h want 7f", an); end
    step();
    step();
    // load coincident with the wrapping tick must take effect for the next frame
    digits = 32'h76543210;
    dp = 8'h01;
    blank_mask = 8'h02;
    load = 1'b1;
    tick = 1'b1;
    step();
    load = 1'b0;
    tick = 1'b0;
    checks++; if (frame_done !== 1'b1) begin fails++; $display("FAIL blank_fd: got %b want 1", frame_done); end
    count_off(n);
    checks++; if (n != 16) begin fails++; $display("FAIL blank_gap0: got %0d want 16", n); end
    checks++; if (an !== 8'hFE) begin fails++; $display("FAIL blank_an0: got %h want fe", an); end
    checks++; if (dp_n !== 1'b0) begin fails++; $display("FAIL blank_dp0: got %b want 0", dp_n); end
    checks++; if (seg !== exp_pat[0]) begin fails++; $display("FAIL blank_seg0: got %b want %b", seg, exp_pat[0]); end
    step();
    step();
    pulse_tick();
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (an !== 8'hFF) bad++;
    end
    checks++; if (bad != 0) begin fails++; $display("FAIL blank_masked: got %0d driven cycles want 0", bad); end
    pulse_tick();
    count_off(n);
    checks++; if (n != 16) begin fails++; $display("FAIL blank_gap1: got %0d want 16", n); end
    checks++; if (an !== 8'hFB) begin fails++; $display("FAIL blank_an2: got %h want fb", an); end
    checks++; if (dp_n !== 1'b1) begin fails++; $display("FAIL blank_dp2: got %b want 1", dp_n); end
    checks++; if (seg !== exp_pat[2]) begin fails++; $display("FAIL blank_seg2: got %b want %b", seg, exp_pat[2]); end
  endtask

  task automatic test_en_drop();
    int n;
    for (int i = 0; i < 3; i++) next_digit(n);
    checks++; if (an !== 8'hDF) begin fails++; $display("FAIL endrop_at5: got %h want df", an); end
    en = 1'b0;
    step();
    checks++; if (an !== 8'hFF) begin fails++; $display("FAIL endrop_an: got %h want ff", an); end
    checks++; if (seg !== 7'h7F) begin fails++; $display("FAIL endrop_seg: got %h want 7f", seg); end
    checks++; if (dp_n !== 1'b1) begin fails++; $display("FAIL endrop_dp_n: got %b want 1", dp_n); end
    step();
    step();
    en = 1'b1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    checks++; if (an !== 8'hFE) begin fails++; $display("FAIL endrop_restart_an: got %h want fe", an); end
    checks++; if (dp_n !== 1'b0) begin fails++; $display("FAIL endrop_restart_dp: got %b want 0", dp_n); end
    // tick arriving together with en falling is ignored
    en = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    checks++; if (an !== 8'hFF) begin fails++; $display("FAIL entick_an: got %h want ff", an); end
    en = 1'b1;
    step();
    step();
    step();
    checks++; if (an !== 8'hFF) begin fails++; $display("FAIL entick_idle: got %h want ff", an); end
  endtask

  task automatic test_reset_mid_drive();
    pulse_tick();
    step();
    checks++; if (an !== 8'hFE) begin fails++; $display("FAIL rstmid_pre: got %h want fe", an); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (an !== 8'hFF) begin fails++; $display("FAIL rstmid_an: got %h want ff", an); end
    checks++; if (seg !== 7'h7F) begin fails++; $display("FAIL rstmid_seg: got %h want 7f", seg); end
    checks++; if (dp_n !== 1'b1) begin fails++; $display("FAIL rstmid_dp_n: got %b want 1", dp_n); end
    step();
    #2 rst_n = 1'b1;
    step();
    checks++; if (an !== 8'hFF) begin fails++; $display("FAIL rstmid_idle: got %h want ff", an); end
    pulse_tick();
    step();
    checks++; if (an !== 8'hFE) begin fails++; $display("FAIL rstmid_restart_an: got %h want fe", an); end
    checks++; if (seg !== 7'b1000000) begin fails++; $display("FAIL rstmid_shadow_seg: got %b want 1000000", seg); end
    checks++; if (dp_n !== 1'b1) begin fails++; $display("FAIL rstmid_shadow_dp: got %b want 1", dp_n); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_wrap();
    test_deferred_load();
    test_blank_dp();
    test_en_drop();
    test_reset_mid_drive();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
